// File: rtl/seven_seg_scan_if.sv
// Display-side bundle for seven_seg_scan: BCD/decimal-point/enable in,
// active-low segment, decimal-point and anode drives out.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    enable;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;

  modport master (output bcd, dp_in, enable, input seg, dp, an);
  modport slave  (input bcd, dp_in, enable, output seg, dp, an);
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with guard interval,
// leading-zero blanking and frame-synchronous input capture.
module seven_seg_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter int GUARD         = 16,
  parameter int BLANK_LEADING = 1
) (
  input logic              clk,
  input logic              rst,
  seven_seg_scan_if.slave  bus
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;

  logic [CW-1:0]           div_cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] bcd_buf;
  logic [NUM_DIGITS-1:0]   dp_buf;
  logic                    load_pending;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;

  logic                    slot_end;
  logic                    frame_end;
  logic                    guard_on;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [NUM_DIGITS-1:0]   sel;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = SEG_OFF;
    endcase
  endfunction

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard_on = 1'b0;
    end else begin : g_guard
      assign guard_on = (div_cnt < CW'(GUARD));
    end
  endgenerate

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    sel       = '0;
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    // A digit is a leading zero when it and everything above it is 0 with no dp.
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      run          = run && (bcd_buf[4*d +: 4] == 4'd0) && !dp_buf[d];
      lead_zero[d] = run;
    end
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx == IW'(d)) begin
        sel[d]    = 1'b1;
        cur_nib   = bcd_buf[4*d +: 4];
        cur_dp    = dp_buf[d];
        cur_blank = (BLANK_LEADING != 0) && (d != 0) && lead_zero[d];
      end
    end

    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    an_nxt  = '1;
    if (bus.enable) begin
      if (!cur_blank) begin
        seg_nxt = decode(cur_nib);
        dp_nxt  = ~cur_dp;
      end
      if (!guard_on) an_nxt = ~sel;
    end
  end

  // NOTE: asynchronous reset is in the sensitivity list so outputs go dark without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt      <= '0;
      idx          <= '0;
      bcd_buf      <= '0;
      dp_buf       <= '0;
      load_pending <= 1'b1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge state.
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (load_pending || frame_end) begin
        bcd_buf      <= bus.bcd;
        dp_buf       <= bus.dp_in;
        load_pending <= 1'b0;
      end
      seg_q <= seg_nxt;
      dp_q  <= dp_nxt;
      an_q  <= an_nxt;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised bench for seven_seg_scan with a cycle-count based reference
// model and hand-computed pins for the documented scenarios.
module tb_seven_seg_scan;
  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int BLANK = 1;
  localparam int FRAME = N * DIV;
  localparam logic [11:0] RST_OUT = {7'b1111111, 1'b1, 4'b1111};
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  logic clk = 1'b0;
  logic rst = 1'b0;
  seven_seg_scan_if #(.NUM_DIGITS(N)) bus();

  seven_seg_scan #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(GRD), .BLANK_LEADING(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: position in the scan is purely the number of edges since reset release.
  function automatic logic [11:0] model_out(input int c, input logic [15:0] b,
                                            input logic [3:0] p, input logic en);
    int pos, d;
    logic [3:0] v;
    logic blank;
    logic [6:0] s;
    logic dpv;
    logic [3:0] a;
    pos = c % DIV;
    d   = (c / DIV) % N;
    v   = b[4*d +: 4];
    blank = 1'b0;
    if (BLANK != 0 && d > 0) begin
      blank = 1'b1;
      for (int j = d; j < N; j++)
        if (b[4*j +: 4] != 4'd0 || p[j]) blank = 1'b0;
    end
    s   = blank ? 7'b1111111 : ((v < 4'd10) ? SEG_TAB[v] : 7'b1111111);
    dpv = blank ? 1'b1 : ~p[d];
    a   = (pos < GRD) ? 4'b1111 : ~(4'b0001 << d);
    if (!en) return RST_OUT;
    return {s, dpv, a};
  endfunction

  int          edge_cnt = 0;
  logic [15:0] m_bcd    = '0;
  logic [3:0]  m_dp     = '0;
  bit          m_pend   = 1'b1;
  logic [11:0] exp_out  = RST_OUT;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt = 0;
      m_bcd    = '0;
      m_dp     = '0;
      m_pend   = 1'b1;
      exp_out  = RST_OUT;
    end else begin
      exp_out = model_out(edge_cnt, m_bcd, m_dp, bus.enable);
      if (m_pend || (edge_cnt % FRAME) == FRAME - 1) begin
        m_bcd  = bus.bcd;
        m_dp   = bus.dp_in;
        m_pend = 1'b0;
      end
      edge_cnt++;
    end
  end

  always @(negedge clk)
    if (chk_en) check("cycle", {20'd0, bus.seg, bus.dp, bus.an}, {20'd0, exp_out});

  task automatic goto(input int k);
    while (edge_cnt < k) @(negedge clk);
  endtask

  task automatic pin_seg_an(input string name, input logic [6:0] s, input logic [3:0] a);
    check(name, {21'd0, bus.seg, bus.an}, {21'd0, s, a});
  endtask

  // Present inputs, wait for the frame load, then pin each digit's mid-slot output.
  task automatic pin_frame(input string name, input logic [15:0] b, input logic [3:0] p,
                           input logic [27:0] es, input logic [3:0] ed, input bit chk_dp);
    int base;
    logic [3:0] a;
    bus.bcd   = b;
    bus.dp_in = p;
    do @(negedge clk); while (edge_cnt % FRAME != 0);
    base = edge_cnt;
    for (int d = 0; d < N; d++) begin
      goto(base + d * DIV + 3);
      a = ~(4'b0001 << d);
      pin_seg_an({name, "_seg"}, es[d*7 +: 7], a);
      if (chk_dp) check({name, "_dp"}, {31'd0, bus.dp}, {31'd0, ed[d]});
    end
  endtask

  function automatic logic [15:0] rnd_bcd();
    logic [15:0] r;
    for (int i = 0; i < N; i++)
      r[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bcd    = 16'h1234;
    bus.dp_in  = 4'b0000;
    bus.enable = 1'b1;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {20'd0, bus.seg, bus.dp, bus.an}, {20'd0, RST_OUT});
    rst = 1'b0;

    goto(1); check("s1_guard_e1", {28'd0, bus.an}, 32'hF);
    goto(2); check("s1_guard_e2", {28'd0, bus.an}, 32'hF);
    for (int k = 3; k <= 8; k++) begin
      goto(k); pin_seg_an("s1_digit0", 7'b0011001, 4'b1110);
    end
    goto(9);  check("s1_guard_e9", {28'd0, bus.an}, 32'hF);
    goto(11); pin_seg_an("frame_d1", 7'b0110000, 4'b1101);
    goto(19); pin_seg_an("frame_d2", 7'b0100100, 4'b1011);
    goto(27); pin_seg_an("frame_d3", 7'b1111001, 4'b0111);
    goto(35); pin_seg_an("frame_wrap", 7'b0011001, 4'b1110);

    goto(42); bus.bcd = 16'h5678;
    goto(51); pin_seg_an("tear_d2", 7'b0100100, 4'b1011);
    goto(59); pin_seg_an("tear_d3", 7'b1111001, 4'b0111);
    goto(67); pin_seg_an("tear_next_d0", 7'b0000000, 4'b1110);

    goto(96);  bus.enable = 1'b0;
    goto(97);  check("en_dark", {20'd0, bus.seg, bus.dp, bus.an}, {20'd0, RST_OUT});
    goto(106); bus.enable = 1'b1;
    goto(107); pin_seg_an("en_restore", 7'b1111000, 4'b1101);

    pin_frame("lz_0070", 16'h0070, 4'b0000,
              {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}, 4'b1111, 1'b1);
    pin_frame("lz_dp", 16'h0070, 4'b0100,
              {7'b1111111, 7'b1000000, 7'b1111000, 7'b1000000}, 4'b1011, 1'b1);
    pin_frame("invalid", 16'h000A, 4'b0001,
              {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, 4'b1110, 1'b0);
    pin_frame("dp_only", 16'h0003, 4'b0001,
              {7'b1111111, 7'b1111111, 7'b1111111, 7'b0110000}, 4'b1110, 1'b1);

    bus.bcd   = 16'h1234;
    bus.dp_in = 4'b0000;
    while (edge_cnt % FRAME != 21) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async_rst", {20'd0, bus.seg, bus.dp, bus.an}, {20'd0, RST_OUT});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    goto(3); pin_seg_an("rst_resume_d0", 7'b0011001, 4'b1110);
    goto(9); check("rst_resume_guard", {28'd0, bus.an}, 32'hF);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        bus.bcd   = rnd_bcd();
        bus.dp_in = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
